// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- multiply/divide unit for the E stage of the MIPS pipeline.
//
// Owns the architectural HI/LO registers. A mult/multu/div/divu result is
// computed on the issue edge and parked in hi_tmp/lo_tmp. A down-counter then
// models the real latency, and HI/LO are committed when the counter expires.
// mthi/mtlo write HI/LO directly. While the unit is busy, every op is ignored.
//
// Parameters
//   MULT_CYCLES  busy duration for mult/multu (1..15)
//   DIV_CYCLES   busy duration for div/divu   (1..15)
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   MDU_op  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A, B    forwarded rs / rt operands
//   start   combinational: MDU_op is a mult/div class op
//   busy    registered: a multiply or divide is in flight
//   HI, LO  architectural HI / LO registers
// -----------------------------------------------------------------------------
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  MDU_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdu_op_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_tmp_q, hi_tmp_d;
  logic [31:0] lo_tmp_q, lo_tmp_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // ---------------------------------------------------------------------------
  // Arithmetic datapath
  // ---------------------------------------------------------------------------
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quot_s, rem_s;
  logic        [31:0] quot_u, rem_u;
  logic               div_ovf;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // -2^31 / -1 is not representable. Force the architected answer so that the
  // result does not depend on how the divider handles the overflow.
  assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  always_comb begin
    if (div_ovf) begin
      quot_s = 32'sh8000_0000;
      rem_s  = 32'sd0;
    end else begin
      // Truncating division; the remainder takes the sign of the dividend.
      quot_s = $signed(A) / $signed(B);
      rem_s  = $signed(A) % $signed(B);
    end
  end

  assign quot_u = A / B;
  assign rem_u  = A % B;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    cnt_d    = cnt_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (cnt_q != 4'd0) begin
      // Running: ops are ignored; commit on the last countdown edge.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = hi_tmp_q;
        lo_d = lo_tmp_q;
      end
    end else begin
      case (MDU_op)
        OP_MULT: begin
          hi_tmp_d = prod_s[63:32];
          lo_tmp_d = prod_s[31:0];
          cnt_d    = MULT_LOAD;
        end
        OP_MULTU: begin
          hi_tmp_d = prod_u[63:32];
          lo_tmp_d = prod_u[31:0];
          cnt_d    = MULT_LOAD;
        end
        OP_DIV, OP_DIVU: begin
          // A divide by zero still occupies the unit but re-commits the
          // current HI/LO, which leaves them unchanged at completion.
          if (B == 32'd0) begin
            hi_tmp_d = hi_q;
            lo_tmp_d = lo_q;
          end else if (MDU_op == OP_DIV) begin
            hi_tmp_d = rem_s;
            lo_tmp_d = quot_s;
          end else begin
            hi_tmp_d = rem_u;
            lo_tmp_d = quot_u;
          end
          cnt_d = DIV_LOAD;
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;  // OP_NONE, OP_RSVD
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: all state is reset, including the temps, so the design never
  // exposes X; a reset mid-operation discards the pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 4'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments make all registers update together
      // from values sampled before the edge.
      cnt_q    <= cnt_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign start = (MDU_op == OP_MULT) || (MDU_op == OP_MULTU) ||
                 (MDU_op == OP_DIV)  || (MDU_op == OP_DIVU);
  assign busy  = (cnt_q != 4'd0);
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the E stage of the five-stage MIPS pipeline, sitting directly downstream of the instruction decoder. It consumes the decoded mult/multu/div/divu/mthi/mtlo class, owns the HI and LO architectural registers, and models multi-cycle latency with a busy counter. The hazard unit uses `start | busy` to stall any MDU-class instruction (including mfhi/mflo) in D.

## Interface
- `MULT_CYCLES`, default 5: busy duration for mult/multu; legal range is 1..15.
- `DIV_CYCLES`, default 10: busy duration for div/divu; legal range is 1..15.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `MDU_op` input 3: operation code.
  - 0: none
  - 1: mult
  - 2: multu
  - 3: div
  - 4: divu
  - 5: mthi
  - 6: mtlo
  - 7: reserved, treated as none.
- `A` input 32: forwarded rs value.
- `B` input 32: forwarded rt value.
- `start` output 1: combinational; asserted when `MDU_op` is 1..4.
- `busy` output 1: registered; asserted while a multiply or divide is in flight.
- `HI` output 32: registered HI register.
- `LO` output 32: registered LO register.

## Operation
- State consists of `cnt[3:0]`, `hi_tmp`/`lo_tmp` (32 bits each), `HI`, and `LO`.
- `busy = (cnt != 0)`.
- Reset (async, `rst_n` = 0): `cnt` = 0, `HI` = 0, `LO` = 0, `hi_tmp` = `lo_tmp` = 0. Therefore `busy` = 0.
- Accept rule: an op is accepted only when `busy` = 0. Any op presented while `busy` = 1 is ignored entirely: no change to `cnt`, temps, HI, or LO. The hazard unit guarantees this never happens; ignoring it is the defined fallback.
- Accepted mult (signed) / multu (unsigned):
  - The 64-bit product of `A` and `B` is latched as `hi_tmp` = product[63:32], `lo_tmp` = product[31:0].
  - `cnt` <= `MULT_CYCLES`.
- Accepted div (signed) / divu (unsigned):
  - `lo_tmp` = quotient, `hi_tmp` = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0.
  - `cnt` <= `DIV_CYCLES`.
- Divide by zero (`B` = 0, div or divu): the op is accepted and `cnt` is loaded, but `hi_tmp`/`lo_tmp` latch the current `HI`/`LO`, so HI and LO are unchanged at completion.
- Countdown: while `cnt` != 0, `cnt` decrements every edge. On the edge where `cnt` == 1, HI <= `hi_tmp` and LO <= `lo_tmp`.
- mthi / mtlo (accepted only when `busy` = 0): HI <= `A` (or LO <= `A`) on the same edge. `cnt` is untouched; no busy is generated.
- No state machine beyond the counter: IDLE is `cnt` = 0, RUN is `cnt` != 0.

## Timing
- An op is issued in cycle T (`start` = 1, `busy` = 0); `cnt` is loaded at the end of T.
- `busy` = 1 in cycles T+1 .. T+N, where N is the configured cycle count.
- New HI/LO are visible from cycle T+N+1, the same cycle `busy` returns to 0.
- A new op may issue in T+N+1 (back-to-back with zero bubble after busy drops).
- mthi/mtlo issued in cycle T are visible on HI/LO in T+1.
- `start` has zero latency and is purely combinational from `MDU_op`.
- Async reset asserted mid-operation: `cnt`, HI, and LO clear immediately, and the pending result is discarded. After deassertion the unit is idle.
- No simultaneous accepted ops are possible: one op per cycle, and ops are rejected while busy.

## Test plan
- Reset then idle: hold `rst_n` = 0, then release -> HI = LO = 0 and `busy` = 0 for 20 cycles with `MDU_op` = 0.
- mult with `A` = 0xFFFFFFFF, `B` = 2, issued at T -> `busy` high T+1..T+5; from T+6 HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. Repeat as multu -> HI = 0x00000001, LO = 0xFFFFFFFE.
- div with `A` = 0xFFFFFFF9 (−7), `B` = 2 -> after 10 busy cycles LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1). divu with `A` = 7, `B` = 0 after mtlo(5)/mthi(9) -> HI = 9, LO = 5 unchanged, `busy` still 10 cycles.
- Overflow corner: div 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Ops ignored while busy:
  - Issue mult(3,4); at T+2 present mthi(0xDEAD) and div(8,2) -> ignored.
  - At T+6, HI = 0 and LO = 12.
  - Immediately issue mtlo(0x55) in T+6 -> LO = 0x55 in T+7.
- Reset mid-operation: issue divu(100,7); pull `rst_n` low at T+4 -> `busy` = 0 and HI = LO = 0 immediately; after release, no late write occurs.
